commit_trace_unit: RTL and testbench

COMMIT_TRACE_UNIT -- requirements
Module: commit_trace_unit

---
 rtl/commit_trace_unit_if.sv | 52 +++++
 rtl/commit_trace_unit.sv | 203 ++++++++++++++++++++
 tb/tb_commit_trace_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_unit_if.sv
//------------------------------------------------------------------------------
// Module      : commit_trace_unit_if
// Description : Bundles the retire-side commit bus, the stall back-pressure
//               line and the record handshake toward the trace consumer.
//               slave  - seen by the trace unit
//               master - seen by the processor / trace consumer side
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface commit_trace_unit_if;
  // Retiring instruction
  logic        commit;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        halt;
  logic        stall;

  // Head record handshake
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_kind;
  logic [15:0] out_inum;
  logic [15:0] out_pc;
  logic [2:0]  out_reg;
  logic [15:0] out_rval;
  logic [15:0] out_addr;
  logic [15:0] out_mval;

  modport slave (
    input  commit, pc, inst, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, out_ready,
    output stall, out_valid, out_kind, out_inum, out_pc, out_reg,
           out_rval, out_addr, out_mval
  );

  modport master (
    output commit, pc, inst, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, out_ready,
    input  stall, out_valid, out_kind, out_inum, out_pc, out_reg,
           out_rval, out_addr, out_mval
  );
endinterface

`default_nettype wire

// File: rtl/commit_trace_unit.sv
//------------------------------------------------------------------------------
// Module      : commit_trace_unit
// Description : Converts each retired instruction into a classified trace
//               record, buffers records in a registered FIFO and hands them
//               to a consumer over a valid/ready handshake. A HALT record
//               moves the unit into a drain phase; once it has been consumed
//               the unit parks in DONE until reset.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               bus         - commit bus + record handshake (slave modport)
//               halted_o    - 1 only in DONE
//               overflow_o  - sticky: a commit arrived while stalled
//               rec_count_o - accepted record count, wraps at 16 bits
// Parameters  : DEPTH - record FIFO depth, power of two, >= 2
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module commit_trace_unit #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  commit_trace_unit_if.slave   bus,
  output logic                 halted_o,
  output logic                 overflow_o,
  output logic [15:0]          rec_count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_STU  = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [2:0]  rreg;
    logic [15:0] rval;
    logic [15:0] addr;
    logic [15:0] mval;
  } rec_t;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [15:0]   inum_q;
  logic          overflow_q;
  logic          halted_q;
  rec_t          mem_q [DEPTH];

  rec_t          push_rec;
  rec_t          head_rec;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;
  logic          drop;
  logic          w_unused_inst;

  // The instruction word is carried on the bus but is not part of a record.
  assign w_unused_inst = ^bus.inst;

  assign full  = (count_q == CNT_FULL);
  assign valid = (count_q != '0) && (state_q != ST_DONE);

  assign push  = bus.commit && (state_q == ST_RUN) && !full;
  assign drop  = bus.commit && (state_q == ST_RUN) && full;
  assign pop   = valid && bus.out_ready;

  // Classification and field masking: only the fields meaningful for the
  // record kind are kept, the rest are forced to zero.
  always_comb begin
    push_rec      = '0;
    push_rec.inum = inum_q;
    push_rec.pc   = bus.pc;
    if (bus.reg_write && bus.mem_write) begin
      push_rec.kind = KIND_STU;
      push_rec.rreg = bus.write_reg;
      push_rec.rval = bus.write_data;
      push_rec.addr = bus.mem_addr;
      push_rec.mval = bus.mem_data;
    end else if (bus.reg_write && bus.mem_read) begin
      push_rec.kind = KIND_LD;
      push_rec.rreg = bus.write_reg;
      push_rec.rval = bus.write_data;
      push_rec.addr = bus.mem_addr;
      push_rec.mval = bus.mem_data;
    end else if (bus.reg_write) begin
      // A register write outranks halt, so halt+reg_write is a REG record.
      push_rec.kind = KIND_REG;
      push_rec.rreg = bus.write_reg;
      push_rec.rval = bus.write_data;
    end else if (bus.halt) begin
      push_rec.kind = KIND_HALT;
    end else if (bus.mem_write) begin
      push_rec.kind = KIND_ST;
      push_rec.addr = bus.mem_addr;
      push_rec.mval = bus.mem_data;
    end else begin
      push_rec.kind = KIND_NOP;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Record storage needs no reset: the head is masked whenever the FIFO is
  // empty, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inum_q     <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        inum_q   <= inum_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (push && (push_rec.kind == KIND_HALT)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // No pushes happen while draining, so the HALT record is the last
          // one; popping the final entry means the HALT has been consumed.
          if (pop && (count_q == CNT_ONE)) begin
            state_q  <= ST_DONE;
            halted_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign head_rec = valid ? mem_q[rd_ptr_q] : '0;

  assign bus.stall     = full;
  assign bus.out_valid = valid;
  assign bus.out_kind  = head_rec.kind;
  assign bus.out_inum  = head_rec.inum;
  assign bus.out_pc    = head_rec.pc;
  assign bus.out_reg   = head_rec.rreg;
  assign bus.out_rval  = head_rec.rval;
  assign bus.out_addr  = head_rec.addr;
  assign bus.out_mval  = head_rec.mval;

  assign halted_o    = halted_q;
  assign overflow_o  = overflow_q;
  assign rec_count_o = inum_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_commit_trace_unit
// Description : Directed self-checking bench for commit_trace_unit (DEPTH=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_commit_trace_unit;

  logic        clk;
  logic        rst;
  logic        halted;
  logic        overflow;
  logic [15:0] rec_count;

  int n_checks = 0;
  int n_errors = 0;

  commit_trace_unit_if bus ();

  commit_trace_unit #(
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halted_o    (halted),
    .overflow_o  (overflow),
    .rec_count_o (rec_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.commit     = 1'b0;
    bus.pc         = 16'h0;
    bus.inst       = 16'h0;
    bus.reg_write  = 1'b0;
    bus.write_reg  = 3'd0;
    bus.write_data = 16'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = 16'h0;
    bus.mem_data   = 16'h0;
    bus.halt       = 1'b0;
  endtask

  task automatic drive(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                       input logic [15:0] wd, input logic mr, input logic mw,
                       input logic [15:0] ma, input logic [15:0] md, input logic hlt);
    bus.commit     = 1'b1;
    bus.pc         = pc;
    bus.inst       = pc ^ 16'h5A5A;
    bus.reg_write  = rw;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.mem_read   = mr;
    bus.mem_write  = mw;
    bus.mem_addr   = ma;
    bus.mem_data   = md;
    bus.halt       = hlt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();

    // ---------------- reset state
    step();
    step();
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_stall",    32'(bus.stall),     32'd0);
    chk("rst_halted",   32'(halted),        32'd0);
    chk("rst_overflow", 32'(overflow),      32'd0);
    chk("rst_count",    32'(rec_count),     32'd0);
    chk("rst_pc",       32'(bus.out_pc),    32'd0);
    rst = 1'b0;

    // ---------------- single REG commit, one-cycle latency, popped next edge
    bus.out_ready = 1'b1;
    drive(16'h0002, 1'b1, 3'd3, 16'h00AB, 1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0);
    step();
    idle_inputs();
    chk("reg_valid", 32'(bus.out_valid), 32'd1);
    chk("reg_kind",  32'(bus.out_kind),  32'd1);
    chk("reg_inum",  32'(bus.out_inum),  32'd0);
    chk("reg_pc",    32'(bus.out_pc),    32'h0002);
    chk("reg_reg",   32'(bus.out_reg),   32'd3);
    chk("reg_rval",  32'(bus.out_rval),  32'h00AB);
    chk("reg_addr",  32'(bus.out_addr),  32'd0);
    chk("reg_mval",  32'(bus.out_mval),  32'd0);
    step();
    chk("reg_popped", 32'(bus.out_valid), 32'd0);
    chk("reg_count",  32'(rec_count),     32'd1);

    // ---------------- kind priority
    do_reset();
    bus.out_ready = 1'b0;
    drive(16'h0004, 1'b1, 3'd5, 16'h1111, 1'b0, 1'b1, 16'h2000, 16'h3333, 1'b0);
    step();
    drive(16'h0006, 1'b1, 3'd6, 16'h4444, 1'b1, 1'b0, 16'h2002, 16'h5555, 1'b0);
    step();
    drive(16'h0008, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    step();
    drive(16'h000A, 1'b0, 3'd2, 16'h9999, 1'b0, 1'b1, 16'h2004, 16'h6666, 1'b0);
    step();
    idle_inputs();
    chk("stu_kind", 32'(bus.out_kind), 32'd4);
    chk("stu_inum", 32'(bus.out_inum), 32'd0);
    chk("stu_reg",  32'(bus.out_reg),  32'd5);
    chk("stu_rval", 32'(bus.out_rval), 32'h1111);
    chk("stu_addr", 32'(bus.out_addr), 32'h2000);
    chk("stu_mval", 32'(bus.out_mval), 32'h3333);
    chk("full_stall", 32'(bus.stall),  32'd1);
    step();
    chk("hold_kind", 32'(bus.out_kind), 32'd4);
    chk("hold_pc",   32'(bus.out_pc),   32'h0004);
    bus.out_ready = 1'b1;
    step();
    chk("ld_kind", 32'(bus.out_kind), 32'd2);
    chk("ld_inum", 32'(bus.out_inum), 32'd1);
    chk("ld_reg",  32'(bus.out_reg),  32'd6);
    chk("ld_rval", 32'(bus.out_rval), 32'h4444);
    chk("ld_addr", 32'(bus.out_addr), 32'h2002);
    chk("stall_clear", 32'(bus.stall), 32'd0);
    step();
    chk("hr_kind", 32'(bus.out_kind), 32'd1);
    chk("hr_inum", 32'(bus.out_inum), 32'd2);
    chk("hr_rval", 32'(bus.out_rval), 32'h7777);
    step();
    chk("st_kind", 32'(bus.out_kind), 32'd3);
    chk("st_inum", 32'(bus.out_inum), 32'd3);
    chk("st_reg",  32'(bus.out_reg),  32'd0);
    chk("st_rval", 32'(bus.out_rval), 32'd0);
    chk("st_addr", 32'(bus.out_addr), 32'h2004);
    chk("st_mval", 32'(bus.out_mval), 32'h6666);
    step();
    chk("prio_empty",  32'(bus.out_valid), 32'd0);
    chk("prio_halted", 32'(halted),        32'd0);
    // Still in RUN: a plain commit is accepted.
    drive(16'h000C, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle_inputs();
    chk("nop_valid", 32'(bus.out_valid), 32'd1);
    chk("nop_kind",  32'(bus.out_kind),  32'd0);
    chk("nop_inum",  32'(bus.out_inum),  32'd4);
    step();

    // ---------------- full FIFO, overflow drop, ordered drain
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(16'h0100 + 16'(i), 1'b1, 3'd1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      step();
      if (i < 3) chk("fill_stall_lo", 32'(bus.stall), 32'd0);
      else       chk("fill_stall_hi", 32'(bus.stall), 32'd1);
    end
    idle_inputs();
    chk("ovf_flag",  32'(overflow),  32'd1);
    chk("ovf_count", 32'(rec_count), 32'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_inum",  32'(bus.out_inum),  32'(i));
      chk("drain_pc",    32'(bus.out_pc),    32'h0100 + 32'(i));
      step();
      if (i == 0) chk("drain_stall", 32'(bus.stall), 32'd0);
    end
    chk("drain_empty",  32'(bus.out_valid), 32'd0);
    chk("ovf_sticky",   32'(overflow),      32'd1);

    // ---------------- HALT behind two records, later commits ignored
    do_reset();
    chk("ovf_reset", 32'(overflow), 32'd0);
    bus.out_ready = 1'b0;
    drive(16'h000C, 1'b1, 3'd1, 16'h0C0C, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    drive(16'h000E, 1'b1, 3'd2, 16'h0E0E, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    drive(16'h0010, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
    drive(16'h0020, 1'b1, 3'd4, 16'h2020, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    chk("drain_ignored_cnt", 32'(rec_count), 32'd3);
    chk("drain_no_ovf",      32'(overflow),  32'd0);
    bus.out_ready = 1'b1;
    chk("h_first",  32'(bus.out_inum), 32'd0);
    step();
    chk("h_second", 32'(bus.out_inum), 32'd1);
    step();
    chk("h_kind",   32'(bus.out_kind), 32'd5);
    chk("h_inum",   32'(bus.out_inum), 32'd2);
    chk("h_pc",     32'(bus.out_pc),   32'h0010);
    chk("h_not_halted", 32'(halted),   32'd0);
    step();
    chk("done_halted", 32'(halted),        32'd1);
    chk("done_valid",  32'(bus.out_valid), 32'd0);
    step();
    step();
    chk("done_stays",  32'(halted),        32'd1);
    chk("done_valid2", 32'(bus.out_valid), 32'd0);
    chk("done_count",  32'(rec_count),     32'd3);
    idle_inputs();

    // ---------------- reset mid-drain with 3 queued records
    do_reset();
    bus.out_ready = 1'b0;
    drive(16'h0030, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    drive(16'h0032, 1'b1, 3'd1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    drive(16'h0034, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
    drive(16'h0036, 1'b1, 3'd2, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    chk("mrst_valid",  32'(bus.out_valid), 32'd0);
    chk("mrst_halted", 32'(halted),        32'd0);
    chk("mrst_stall",  32'(bus.stall),     32'd0);
    chk("mrst_count",  32'(rec_count),     32'd0);
    drive(16'h0038, 1'b1, 3'd4, 16'h0044, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle_inputs();
    chk("mrst_next_valid", 32'(bus.out_valid), 32'd1);
    chk("mrst_next_inum",  32'(bus.out_inum),  32'd0);
    chk("mrst_next_pc",    32'(bus.out_pc),    32'h0038);

    // ---------------- INUM / rec_count wrap after 65536 accepted commits
    do_reset();
    bus.out_ready = 1'b1;
    drive(16'h0040, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      step();
    end
    chk("wrap_last_inum", 32'(bus.out_inum), 32'hFFFF);
    chk("wrap_count",     32'(rec_count),    32'd0);
    chk("wrap_no_stall",  32'(bus.stall),    32'd0);
    step();
    idle_inputs();
    chk("wrap_inum", 32'(bus.out_inum), 32'h0000);
    chk("wrap_count_after", 32'(rec_count), 32'd1);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);
    step();
    chk("wrap_empty", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
